telemetry_framer: RTL and testbench

//  Frames the sensor register bank into a serial telemetry packet for the data radio link.

---
 rtl/telemetry_framer.sv | 182 ++++++++++++++++++
 tb/tb_telemetry_framer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_framer.sv
// Serial telemetry framer: reads the sensor register bank byte by byte and streams
// SYNC0, SYNC1, LEN, payload, CKSUM to a byte-wide serial transmitter.
module telemetry_framer #(
    parameter int unsigned NUM_BYTES     = 64,
    parameter int unsigned PERIOD_CYCLES = 5000000,
    parameter logic [7:0]  SYNC0         = 8'hA5,
    parameter logic [7:0]  SYNC1         = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] snsr_addr,
    input  logic [7:0] snsr_data,
    output logic [7:0] tx_data,
    output logic       tx_new_data,
    input  logic       tx_busy,
    input  logic       tx_block,
    output logic       frame_busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StAddr, StRead, StSend, StWait, StDone
    } state_e;

    typedef enum logic [2:0] {
        KindSync0, KindSync1, KindLen, KindPay, KindCksum
    } kind_e;

    localparam logic [7:0]  LenByte = 8'(NUM_BYTES);
    localparam logic [31:0] PerLast = (PERIOD_CYCLES == 0) ? 32'd0 : 32'(PERIOD_CYCLES - 1);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  cksum_q, cksum_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        wait_first_q, wait_first_d;
    logic        pending_q, pending_d;
    logic        pend_clr;
    logic        per_tick;
    logic [31:0] per_cnt_q;

    assign per_tick = (PERIOD_CYCLES != 0) && (per_cnt_q == PerLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= 32'd0;
        end else if (per_tick || (PERIOD_CYCLES == 0)) begin
            per_cnt_q <= 32'd0;
        end else begin
            per_cnt_q <= per_cnt_q + 32'd1;
        end
    end

    // A new request wins over the clear so a request arriving as a frame starts is kept.
    assign pending_d = (pending_q & ~pend_clr) | start | per_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            kind_q       <= KindSync0;
            byte_q       <= 8'h00;
            cksum_q      <= 8'h00;
            idx_q        <= 8'h00;
            addr_q       <= 8'h00;
            busy_q       <= 1'b0;
            wait_first_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            byte_q       <= byte_d;
            cksum_q      <= cksum_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            wait_first_q <= wait_first_d;
            pending_q    <= pending_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        byte_d       = byte_q;
        cksum_d      = cksum_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        wait_first_d = wait_first_q;
        pend_clr     = 1'b0;
        tx_new_data  = 1'b0;
        frame_done   = 1'b0;
        snsr_addr    = addr_q;

        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    pend_clr = 1'b1;
                    busy_d   = 1'b1;
                    cksum_d  = 8'h00;
                    idx_d    = 8'h00;
                    kind_d   = KindSync0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                case (kind_q)
                    KindSync0: byte_d = SYNC0;
                    KindSync1: byte_d = SYNC1;
                    KindLen: begin
                        byte_d  = LenByte;
                        cksum_d = cksum_q + LenByte;
                    end
                    default:   byte_d = cksum_q;
                endcase
                state_d = StSend;
            end
            StAddr: begin
                // Address goes out combinationally so the registered read lands in StRead.
                snsr_addr = idx_q;
                addr_d    = idx_q;
                state_d   = StRead;
            end
            StRead: begin
                byte_d  = snsr_data;
                cksum_d = cksum_q + snsr_data;
                idx_d   = idx_q + 8'd1;
                state_d = StSend;
            end
            StSend: begin
                if (!tx_busy && !tx_block) begin
                    tx_new_data  = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!tx_busy) begin
                    case (kind_q)
                        KindSync0: begin
                            kind_d  = KindSync1;
                            state_d = StLoad;
                        end
                        KindSync1: begin
                            kind_d  = KindLen;
                            state_d = StLoad;
                        end
                        KindLen: begin
                            kind_d  = KindPay;
                            state_d = StAddr;
                        end
                        KindPay: begin
                            if (idx_q == LenByte) begin
                                kind_d  = KindCksum;
                                state_d = StLoad;
                            end else begin
                                state_d = StAddr;
                            end
                        end
                        default: state_d = StDone;
                    endcase
                end
            end
            StDone: begin
                frame_done = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign tx_data    = byte_q;
    assign frame_busy = busy_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: frame content, flow control, checksum wrap,
// request collapsing, mid-frame reset and the periodic trigger.
module tb_telemetry_framer;

    localparam int BusyCyc = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] snsr_addr;
    logic [7:0] snsr_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_new_data;
    logic       tx_busy = 1'b0;
    logic       tx_block = 1'b0;
    logic       frame_busy;
    logic       frame_done;
    logic       ff_mode = 1'b0;

    logic       rst2_n = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] snsr_addr2;
    logic [7:0] snsr_data2 = 8'h00;
    logic [7:0] tx_data2;
    logic       tx_new_data2;
    logic       tx_busy2 = 1'b0;
    logic       frame_busy2;
    logic       frame_done2;

    int checks = 0;
    int failures = 0;

    int         cyc = 0;
    int         rx_n = 0;
    int         nd_cnt = 0;
    int         done_cnt = 0;
    int         viol = 0;
    logic       prev_nd = 1'b0;
    logic [7:0] rx_mem [0:511];
    int         busy_cnt = 0;
    int         busy_cnt2 = 0;
    int         d2_n = 0;
    int         d2_mem [0:7];

    logic [7:0] exp_basic [0:7] = '{8'hA5, 8'h5A, 8'h04, 8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'hFA};
    logic [7:0] exp_ff    [0:7] = '{8'hA5, 8'h5A, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};

    telemetry_framer #(
        .NUM_BYTES     (4),
        .PERIOD_CYCLES (0),
        .SYNC0         (8'hA5),
        .SYNC1         (8'h5A)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .snsr_addr   (snsr_addr),
        .snsr_data   (snsr_data),
        .tx_data     (tx_data),
        .tx_new_data (tx_new_data),
        .tx_busy     (tx_busy),
        .tx_block    (tx_block),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done)
    );

    telemetry_framer #(
        .NUM_BYTES     (4),
        .PERIOD_CYCLES (20000),
        .SYNC0         (8'hA5),
        .SYNC1         (8'h5A)
    ) dut_per (
        .clk         (clk),
        .rst_n       (rst2_n),
        .start       (start2),
        .snsr_addr   (snsr_addr2),
        .snsr_data   (snsr_data2),
        .tx_data     (tx_data2),
        .tx_new_data (tx_new_data2),
        .tx_busy     (tx_busy2),
        .tx_block    (1'b0),
        .frame_busy  (frame_busy2),
        .frame_done  (frame_done2)
    );

    always #5 clk = ~clk;

    // Registered sensor read and a serial_tx stand-in with registered busy.
    always @(posedge clk) begin
        snsr_data  <= ff_mode ? 8'hFF : (snsr_addr ^ 8'h3C);
        snsr_data2 <= snsr_addr2 ^ 8'h3C;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end else if (tx_new_data) begin
            busy_cnt <= BusyCyc;
            tx_busy  <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            busy_cnt2 <= 0;
            tx_busy2  <= 1'b0;
        end else if (tx_new_data2) begin
            busy_cnt2 <= BusyCyc;
            tx_busy2  <= 1'b1;
        end else if (busy_cnt2 > 1) begin
            busy_cnt2 <= busy_cnt2 - 1;
        end else begin
            busy_cnt2 <= 0;
            tx_busy2  <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        prev_nd <= tx_new_data;
        if (rst_n && tx_new_data) begin
            rx_mem[rx_n % 512] <= tx_data;
            rx_n   <= rx_n + 1;
            nd_cnt <= nd_cnt + 1;
        end
        if (rst_n && tx_new_data && (tx_busy || tx_block || prev_nd)) viol <= viol + 1;
        if (rst_n && frame_done) done_cnt <= done_cnt + 1;
        if (rst2_n && frame_done2 && d2_n < 8) begin
            d2_mem[d2_n] <= cyc;
            d2_n         <= d2_n + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (snsr_addr !== 8'h00) begin
            failures++; $display("FAIL reset_addr got=%h exp=00", snsr_addr);
        end
        if (tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data);
        end
        if (tx_new_data !== 1'b0) begin
            failures++; $display("FAIL reset_new_data got=%b exp=0", tx_new_data);
        end
        if (frame_busy !== 1'b0) begin
            failures++; $display("FAIL reset_frame_busy got=%b exp=0", frame_busy);
        end
        if (frame_done !== 1'b0) begin
            failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int base, d0;
        bit ok;
        base = rx_n;
        d0   = done_cnt;
        pulse_start();
        wait_done(d0 + 1, 1000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL basic_timeout got=no_done exp=done");
        end
        repeat (50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_mem[(base + i) % 512] !== exp_basic[i]) begin
                failures++;
                $display("FAIL basic_byte%0d got=%h exp=%h", i, rx_mem[(base + i) % 512],
                         exp_basic[i]);
            end
        end
        checks += 3;
        if (rx_n - base !== 8) begin
            failures++; $display("FAIL basic_count got=%0d exp=8", rx_n - base);
        end
        if (done_cnt !== d0 + 1) begin
            failures++; $display("FAIL basic_done_count got=%0d exp=%0d", done_cnt, d0 + 1);
        end
        if (frame_busy !== 1'b0) begin
            failures++; $display("FAIL basic_busy_after got=%b exp=0", frame_busy);
        end
    endtask

    task automatic test_tx_block();
        int base, d0, nd0;
        bit ok;
        base = rx_n;
        d0   = done_cnt;
        pulse_start();
        wait_bytes(base + 4, 1000, ok);
        @(negedge clk);
        tx_block = 1'b1;
        nd0 = nd_cnt;
        repeat (2000) @(negedge clk);
        checks += 2;
        if (nd_cnt !== nd0) begin
            failures++; $display("FAIL block_strobes got=%0d exp=0", nd_cnt - nd0);
        end
        if (frame_busy !== 1'b1) begin
            failures++; $display("FAIL block_frame_busy got=%b exp=1", frame_busy);
        end
        tx_block = 1'b0;
        wait_done(d0 + 1, 1000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL block_timeout got=no_done exp=done");
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_mem[(base + i) % 512] !== exp_basic[i]) begin
                failures++;
                $display("FAIL block_byte%0d got=%h exp=%h", i, rx_mem[(base + i) % 512],
                         exp_basic[i]);
            end
        end
    endtask

    task automatic test_cksum_ff();
        int base, d0;
        bit ok;
        base    = rx_n;
        d0      = done_cnt;
        ff_mode = 1'b1;
        pulse_start();
        wait_done(d0 + 1, 1000, ok);
        ff_mode = 1'b0;
        checks++;
        if (!ok) begin
            failures++; $display("FAIL ff_timeout got=no_done exp=done");
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_mem[(base + i) % 512] !== exp_ff[i]) begin
                failures++;
                $display("FAIL ff_byte%0d got=%h exp=%h", i, rx_mem[(base + i) % 512], exp_ff[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, d0;
        bit ok;
        base = rx_n;
        d0   = done_cnt;
        pulse_start();
        wait_bytes(base + 3, 1000, ok);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            repeat (7) @(negedge clk);
        end
        wait_done(d0 + 2, 2000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", done_cnt - d0, 2);
        end
        repeat (400) @(negedge clk);
        checks += 2;
        if (done_cnt !== d0 + 2) begin
            failures++; $display("FAIL b2b_frames got=%0d exp=2", done_cnt - d0);
        end
        if (rx_n - base !== 16) begin
            failures++; $display("FAIL b2b_bytes got=%0d exp=16", rx_n - base);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx_mem[(base + i) % 512] !== exp_basic[i % 8]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_mem[(base + i) % 512],
                         exp_basic[i % 8]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base, d0;
        bit ok, seen;
        base = rx_n;
        pulse_start();
        wait_bytes(base + 5, 1000, ok);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_new_data) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL midrst_strobe got=none exp=strobe");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (tx_new_data !== 1'b0) begin
            failures++; $display("FAIL midrst_new_data got=%b exp=0", tx_new_data);
        end
        if (tx_data !== 8'h00) begin
            failures++; $display("FAIL midrst_tx_data got=%h exp=00", tx_data);
        end
        if (snsr_addr !== 8'h00) begin
            failures++; $display("FAIL midrst_addr got=%h exp=00", snsr_addr);
        end
        if (frame_busy !== 1'b0) begin
            failures++; $display("FAIL midrst_busy got=%b exp=0", frame_busy);
        end
        if (frame_done !== 1'b0) begin
            failures++; $display("FAIL midrst_done got=%b exp=0", frame_done);
        end
        if (rx_n - base !== 5) begin
            failures++; $display("FAIL midrst_partial got=%0d exp=5", rx_n - base);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        base = rx_n;
        d0   = done_cnt;
        pulse_start();
        wait_done(d0 + 1, 1000, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL midrst_timeout got=no_done exp=done");
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_mem[(base + i) % 512] !== exp_basic[i]) begin
                failures++;
                $display("FAIL midrst_byte%0d got=%h exp=%h", i, rx_mem[(base + i) % 512],
                         exp_basic[i]);
            end
        end
    endtask

    task automatic test_period();
        while (cyc < 61000) @(negedge clk);
        checks++;
        if (d2_n < 3) begin
            failures++; $display("FAIL period_frames got=%0d exp>=3", d2_n);
        end else begin
            checks += 3;
            if (d2_mem[1] - d2_mem[0] !== 20000) begin
                failures++; $display("FAIL period_gap1 got=%0d exp=20000", d2_mem[1] - d2_mem[0]);
            end
            if (d2_mem[2] - d2_mem[1] !== 20000) begin
                failures++; $display("FAIL period_gap2 got=%0d exp=20000", d2_mem[2] - d2_mem[1]);
            end
            if (d2_mem[0] < 20000 || d2_mem[0] > 20400) begin
                failures++; $display("FAIL period_first got=%0d exp=20000..20400", d2_mem[0]);
            end
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            failures++; $display("FAIL strobe_protocol got=%0d violations exp=0", viol);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        test_reset();
        test_basic_frame();
        test_tx_block();
        test_cksum_ff();
        test_back_to_back();
        test_reset_midframe();
        test_period();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
